// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, common to uart_rx and UART_tx.
package uart_pkg;

  localparam logic [11:0] BAUD_DIV_DFLT = 12'd2604;
  localparam logic [11:0] HALF_DIV_DFLT = 12'd1302;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable 12-bit down-counter; shift_o marks the cycle whose edge takes the count to zero.
module uart_baud_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [11:0] load_val_i,
  output logic        shift_o
);

  logic [11:0] cnt_q, cnt_d;

  // A load of N makes shift_o fire N cycles later, so the sample period is exactly N.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 12'd0) begin
      cnt_d = cnt_q - 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 12'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign shift_o = (cnt_q == 12'd1);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with rdy/clr_rdy byte handshake, framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [11:0] BAUD_DIV = BAUD_DIV_DFLT,
  parameter logic [11:0] HALF_DIV = HALF_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err,
  output rx_state_t  state_o
);

  // Handshake: rdy rises in the cycle after a good stop bit and stays high with
  // rx_data frozen until clr_rdy; clr_rdy coinciding with a new byte loses to the set.
  rx_state_t   state_q, state_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frm_q, frm_d;
  logic        ovr_q, ovr_d;
  logic        load;
  logic [11:0] load_val;
  logic        shift;
  logic        rx_s;
  logic        fall;

  assign rx_s = sync2_q;
  assign fall = sync3_q & ~sync2_q;

  uart_baud_cnt u_baud (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .shift_o    (shift)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    rdy_d     = clr_rdy ? 1'b0 : rdy_q;
    ovr_d     = clr_rdy ? 1'b0 : ovr_q;
    frm_d     = 1'b0;
    load      = 1'b0;
    load_val  = BAUD_DIV;
    case (state_q)
      IDLE: begin
        if (fall) begin
          load     = 1'b1;
          load_val = HALF_DIV;
          state_d  = START;
        end
      end
      START: begin
        if (shift) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            load      = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (shift) begin
          load      = 1'b1;
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (shift) begin
          state_d = IDLE;
          if (rx_s) begin
            rx_data_d = shreg_q;
            rdy_d     = 1'b1;
            if (rdy_q && !clr_rdy) begin
              ovr_d = 1'b1;
            end
          end else begin
            frm_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      frm_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      frm_q     <= frm_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_q;
  assign ovr_err = ovr_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Loopback-style bench for uart_rx: a bit-level transmitter task feeds RX, a scoreboard checks every accepted byte.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int B = 64;
  localparam int H = 32;
  localparam int LAT = 3 + H + 9 * B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  rx_state_t  state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int frm_cnt = 0;
  int last_acc_cyc = -1;
  int t0 = 0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .BAUD_DIV (12'(B)),
    .HALF_DIV (12'(H))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err),
    .state_o (state)
  );

  // clock / reset
  always #10 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d reached, limit 100000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit push, input int rst_bit);
    if (push) exp_q.push_back(b);
    t0 = cyc;
    rx = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_bit) begin
        tick(B / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_rdy", 16'(rdy), 16'h0);
        check("rst_frm", 16'(frm_err), 16'h0);
        check("rst_ovr", 16'(ovr_err), 16'h0);
        check("rst_data", 16'(rx_data), 16'h00);
        check("rst_state", 16'(state), 16'(IDLE));
        tick(B - B / 2 - 1);
      end else begin
        tick(B);
      end
    end
    rx = stop;
    tick(B);
  endtask

  // scoreboard monitor: an accepted byte shows as rdy rising, ovr_err rising, or new data under rdy
  initial begin
    logic rdy_p, ovr_p, frm_p;
    logic [7:0] data_p;
    logic [7:0] exp;
    rdy_p = 1'b0; ovr_p = 1'b0; frm_p = 1'b0; data_p = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ((rdy && !rdy_p) || (ovr_err && !ovr_p) || (rdy && rdy_p && rx_data != data_p)) begin
          last_acc_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got byte %h want no byte", rx_data);
          end else begin
            exp = exp_q.pop_front();
            check("sb_byte", 16'(rx_data), 16'(exp));
          end
        end
        if (frm_err) begin
          frm_cnt++;
          check("frm_width", 16'(frm_p), 16'h0);
        end
      end
      rdy_p = rdy; ovr_p = ovr_err; frm_p = frm_err; data_p = rx_data;
    end
  end

  initial begin
    int base;
    int lat;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_rdy", 16'(rdy), 16'h0);
    check("reset_frm", 16'(frm_err), 16'h0);
    check("reset_ovr", 16'(ovr_err), 16'h0);
    check("reset_data", 16'(rx_data), 16'h00);
    check("reset_state", 16'(state), 16'(IDLE));
    tick(10);

    // single byte, latency window
    send_frame(8'h67, 1'b1, 1'b1, -1);
    lat = last_acc_cyc - t0;
    n_cmp++;
    if (lat < LAT - 3 || lat > LAT + 3) begin
      n_err++;
      $display("FAIL latency: got %0d clks want %0d..%0d", lat, LAT - 3, LAT + 3);
    end
    check("g_data", 16'(rx_data), 16'h67);
    check("g_rdy", 16'(rdy), 16'h1);
    check("g_ovr", 16'(ovr_err), 16'h0);
    check("g_frm_cnt", 16'(frm_cnt), 16'd0);
    pulse_clr();
    check("g_clr_rdy", 16'(rdy), 16'h0);

    // back-to-back overrun
    send_frame(8'h73, 1'b1, 1'b1, -1);
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    tick(2);
    check("ovr_data", 16'(rx_data), 16'hA5);
    check("ovr_rdy", 16'(rdy), 16'h1);
    check("ovr_flag", 16'(ovr_err), 16'h1);
    pulse_clr();
    check("ovr_clr_rdy", 16'(rdy), 16'h0);
    check("ovr_clr_flag", 16'(ovr_err), 16'h0);

    // framing error, then line held low
    base = frm_cnt;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    tick(30 * B);
    check("frm_once", 16'(frm_cnt - base), 16'd1);
    check("frm_rdy", 16'(rdy), 16'h0);
    rx = 1'b1;
    tick(2 * B);
    check("frm_break_cnt", 16'(frm_cnt - base), 16'd1);
    check("frm_idle", 16'(state), 16'(IDLE));
    tick(10);

    // short glitch rejected, then a good byte
    base = frm_cnt;
    rx = 1'b0;
    tick(10);
    rx = 1'b1;
    tick(H + 20);
    check("glitch_state", 16'(state), 16'(IDLE));
    check("glitch_rdy", 16'(rdy), 16'h0);
    check("glitch_ovr", 16'(ovr_err), 16'h0);
    check("glitch_frm", 16'(frm_cnt - base), 16'd0);
    send_frame(8'h67, 1'b1, 1'b1, -1);
    check("post_glitch_data", 16'(rx_data), 16'h67);
    check("post_glitch_rdy", 16'(rdy), 16'h1);
    pulse_clr();
    tick(10);

    // reset during bit 4 discards the frame
    send_frame(8'hFF, 1'b1, 1'b0, 4);
    tick(2 * B);
    check("rst_tail_rdy", 16'(rdy), 16'h0);
    send_frame(8'h00, 1'b1, 1'b1, -1);
    check("zero_rdy", 16'(rdy), 16'h1);
    check("zero_data", 16'(rx_data), 16'h00);

    // clr_rdy lands on the stop-accept edge while rdy is already high
    fork
      send_frame(8'h3C, 1'b1, 1'b1, -1);
      begin
        tick(LAT - 1);
        pulse_clr();
      end
    join
    check("setwins_rdy", 16'(rdy), 16'h1);
    check("setwins_data", 16'(rx_data), 16'h3C);
    check("setwins_ovr", 16'(ovr_err), 16'h0);

    tick(10);
    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
